button_debounce: RTL and testbench

Upstream input-conditioning stage for the Alhambra II LED examples. Takes a raw, bouncing push-button, synchronises it to the 12 MHz clock and debounces it. Emits a clean level plus single-cycle press, release and long-press strobes. The blink/LED stage consumes these strobes to start, stop or re-rate its pattern.

---
 rtl/button_debounce_pkg.sv | 25 ++
 rtl/sync2.sv | 37 +++
 rtl/button_debounce.sv | 160 ++++++++++++++++
 tb/tb_button_debounce.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_pkg
//  Description : Shared definitions for the push-button input blocks.
//                Provides the debounce FSM state encoding and the default
//                timing constants for a 12 MHz system clock.
//  Contents    : state_t (IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3),
//                c_DEBOUNCE_CYCLES_12M, c_LONG_CYCLES_12M
//  Revision    : 1.0 - initial release
// ============================================================================
package button_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // 10 ms debounce window and 1 s long-press threshold at 12 MHz.
    localparam int unsigned c_DEBOUNCE_CYCLES_12M = 120000;
    localparam int unsigned c_LONG_CYCLES_12M     = 12000000;

endpackage : button_debounce_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Generic two-flop synchroniser for a single asynchronous bit.
//  Ports       : CLK  in  destination clock
//                RST  in  asynchronous active-high reset
//                D    in  asynchronous input
//                Q    out synchronised output (2-cycle latency)
//  Parameters  : RESET_VALUE - value both flops take while RST is high
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= D;
            r_sync <= r_meta;
        end
    end

    assign Q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Synchronises and debounces a raw push-button. Produces a
//                clean level plus one-cycle press, release and long-press
//                strobes, all registered.
//  Ports       : CLK      in  system clock (12 MHz)
//                RST      in  asynchronous active-high reset
//                BTN      in  raw button pin, asynchronous to CLK
//                PRESSED  out debounced level, 1 while held
//                PRESS    out one-cycle strobe on accepted press
//                RELEASE  out one-cycle strobe on accepted release
//                LONG     out one-cycle strobe, once per press, after
//                             LONG_CYCLES spent in HELD
//  Parameters  : DEBOUNCE_CYCLES (>=2), LONG_CYCLES (>=2), ACTIVE_LOW
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_12M,
    parameter int unsigned LONG_CYCLES     = c_LONG_CYCLES_12M,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic PRESSED,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG
);

    localparam int c_CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int c_LCNT_W = $clog2(LONG_CYCLES);

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_LCNT_W-1:0] c_LCNT_LAST = c_LCNT_W'(LONG_CYCLES - 1);

    // Polarity is normalised before the synchroniser so that its reset
    // value of 0 always means "released".
    logic w_btn_norm;
    logic w_b;

    assign w_btn_norm = BTN ^ ACTIVE_LOW;

    sync2 #(
        .RESET_VALUE (1'b0)
    ) u_sync2 (
        .CLK (CLK),
        .RST (RST),
        .D   (w_btn_norm),
        .Q   (w_b)
    );

    state_t              r_state,     w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic [c_LCNT_W-1:0] r_lcnt,      w_lcnt_nxt;
    logic                r_long_done, w_long_done_nxt;
    logic                r_pressed,   w_pressed_nxt;
    logic                r_press,     w_press_nxt;
    logic                r_release,   w_release_nxt;
    logic                r_long,      w_long_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_lcnt      <= '0;
            r_long_done <= 1'b0;
            r_pressed   <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lcnt      <= w_lcnt_nxt;
            r_long_done <= w_long_done_nxt;
            r_pressed   <= w_pressed_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_long      <= w_long_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_lcnt_nxt      = r_lcnt;
        w_long_done_nxt = r_long_done;
        w_pressed_nxt   = r_pressed;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_b) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!w_b) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt     = HELD;
                    w_press_nxt     = 1'b1;
                    w_pressed_nxt   = 1'b1;
                    w_lcnt_nxt      = '0;
                    w_long_done_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            HELD: begin
                if (!w_b) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end else if (!r_long_done) begin
                    // lcnt parks at its limit once LONG has fired.
                    if (r_lcnt == c_LCNT_LAST) begin
                        w_long_nxt      = 1'b1;
                        w_long_done_nxt = 1'b1;
                    end else begin
                        w_lcnt_nxt = r_lcnt + 1'b1;
                    end
                end
            end

            RELEASE_WAIT: begin
                // A bounce back to 1 resumes HELD with lcnt/long_done
                // untouched, so a long press is not re-armed by chatter.
                if (w_b) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                    w_pressed_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign PRESSED = r_pressed;
    assign PRESS   = r_press;
    assign RELEASE = r_release;
    assign LONG    = r_long;

endmodule : button_debounce
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce
//  Description : Directed self-checking bench for button_debounce with
//                DEBOUNCE_CYCLES=4, LONG_CYCLES=20. Instance A is
//                active-high, instance B is active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    localparam int unsigned c_DEB  = 4;
    localparam int unsigned c_LONG = 20;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic btn_a = 1'b0;
    logic btn_b = 1'b1;

    logic pressed_a, press_a, release_a, long_a;
    logic pressed_b, press_b, release_b, long_b;

    int n_cmp = 0;
    int n_err = 0;

    // Event counters, sampled on the falling edge (away from the active edge).
    int np_a = 0, nr_a = 0, nl_a = 0, nhi_a = 0, nlo_a = 0;
    int np_b = 0, nr_b = 0, nl_b = 0;
    int n_excl = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES (c_DEB),
        .LONG_CYCLES     (c_LONG),
        .ACTIVE_LOW      (1'b0)
    ) u_dut_a (
        .CLK     (clk),
        .RST     (rst),
        .BTN     (btn_a),
        .PRESSED (pressed_a),
        .PRESS   (press_a),
        .RELEASE (release_a),
        .LONG    (long_a)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (c_DEB),
        .LONG_CYCLES     (c_LONG),
        .ACTIVE_LOW      (1'b1)
    ) u_dut_b (
        .CLK     (clk),
        .RST     (rst),
        .BTN     (btn_b),
        .PRESSED (pressed_b),
        .PRESS   (press_b),
        .RELEASE (release_b),
        .LONG    (long_b)
    );

    always @(negedge clk) begin
        if (press_a)   np_a++;
        if (release_a) nr_a++;
        if (long_a)    nl_a++;
        if (pressed_a) nhi_a++;
        else           nlo_a++;
        if (press_b)   np_b++;
        if (release_b) nr_b++;
        if (long_b)    nl_b++;
        if ((int'(press_a) + int'(release_a) + int'(long_a)) > 1) n_excl++;
        if ((int'(press_b) + int'(release_b) + int'(long_b)) > 1) n_excl++;
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int s_np, s_nr, s_nl, s_hi, s_lo;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_pressed_a", int'(pressed_a), 0);
        check("rst_press_a",   int'(press_a),   0);
        check("rst_release_a", int'(release_a), 0);
        check("rst_long_a",    int'(long_a),    0);
        check("rst_pressed_b", int'(pressed_b), 0);
        check("rst_press_b",   int'(press_b),   0);
        rst = 1'b0;

        // Active-low instance sees BTN=1 (released): nothing may happen.
        repeat (10) tick();
        check("al_idle_strobes", np_b + nr_b + nl_b, 0);
        check("al_idle_pressed", int'(pressed_b), 0);

        // ---------------- clean press (A) / active-low press (B) ----------------
        btn_a = 1'b1;
        btn_b = 1'b0;
        repeat (6) tick();                       // after edge 5
        check("press_e5_a",   int'(press_a),   0);
        check("pressed_e5_a", int'(pressed_a), 0);
        check("press_e5_b",   int'(press_b),   0);
        tick();                                  // after edge 6
        check("press_e6_a",   int'(press_a),   1);
        check("pressed_e6_a", int'(pressed_a), 1);
        check("press_e6_b",   int'(press_b),   1);
        check("pressed_e6_b", int'(pressed_b), 1);
        tick();                                  // after edge 7
        check("press_e7_a",   int'(press_a),   0);
        check("pressed_e7_a", int'(pressed_a), 1);
        check("press_e7_b",   int'(press_b),   0);

        // ---------------- long press ----------------
        repeat (18) tick();                      // after edge 25
        check("long_e25_a", int'(long_a), 0);
        tick();                                  // after edge 26 = HELD entry + 20
        check("long_e26_a", int'(long_a), 1);
        check("long_e26_b", int'(long_b), 1);
        tick();
        check("long_e27_a", int'(long_a), 0);
        repeat (12) tick();                      // held through edge 39

        btn_a = 1'b0;
        btn_b = 1'b1;
        repeat (6) tick();
        check("rel_e5_a",     int'(release_a), 0);
        check("rel_e5_pr_a",  int'(pressed_a), 1);
        tick();
        check("rel_e6_a",     int'(release_a), 1);
        check("rel_e6_pr_a",  int'(pressed_a), 0);
        check("rel_e6_b",     int'(release_b), 1);
        tick();
        check("rel_e7_a",     int'(release_a), 0);
        check("long_cnt_a",   nl_a, 1);
        check("press_cnt_a",  np_a, 1);
        check("rel_cnt_a",    nr_a, 1);
        check("long_cnt_b",   nl_b, 1);

        // ---------------- bounce ----------------
        s_np = np_a; s_nr = nr_a; s_nl = nl_a; s_hi = nhi_a;
        for (int i = 0; i < 15; i++) begin
            btn_a = (i % 2 == 0);
            repeat (2) tick();
        end
        btn_a = 1'b0;
        repeat (10) tick();
        check("bounce_strobes", (np_a - s_np) + (nr_a - s_nr) + (nl_a - s_nl), 0);
        check("bounce_pressed", nhi_a - s_hi, 0);

        // ---------------- release bounce in HELD ----------------
        btn_a = 1'b1;
        repeat (7) tick();                       // after edge 6
        check("rb_press", int'(press_a), 1);
        tick();                                  // after edge 7
        s_np = np_a; s_nr = nr_a; s_nl = nl_a; s_lo = nlo_a;
        repeat (2) tick();                       // after edge 9
        btn_a = 1'b0;
        repeat (2) tick();                       // edges 10,11 sample 0
        btn_a = 1'b1;
        repeat (17) tick();                      // after edge 28
        check("rb_long_e28", int'(long_a), 0);
        tick();                                  // after edge 29 (3 edges without lcnt advance)
        check("rb_long_e29", int'(long_a), 1);
        repeat (20) tick();
        check("rb_long_cnt",  nl_a - s_nl, 1);
        check("rb_press_cnt", np_a - s_np, 0);
        check("rb_rel_cnt",   nr_a - s_nr, 0);
        check("rb_low_cyc",   nlo_a - s_lo, 0);

        // ---------------- reset mid-press ----------------
        check("mr_pressed_before", int'(pressed_a), 1);
        rst = 1'b1;
        #1;
        check("mr_pressed", int'(pressed_a), 0);
        check("mr_strobes", int'(press_a) + int'(release_a) + int'(long_a), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("mr_press_e5", int'(press_a), 0);
        tick();
        check("mr_press_e6",   int'(press_a),   1);
        check("mr_pressed_e6", int'(pressed_a), 1);
        btn_a = 1'b0;
        repeat (10) tick();
        check("end_pressed_a", int'(pressed_a), 0);
        check("excl_viol",     n_excl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_button_debounce
`default_nettype wire
